// File: rtl/pair_serial_tx.sv
// Bit-serial transmitter for (x, y) operand pairs with first/last framing,
// ready backpressure and per-frame bitwise-equality summaries (all/any XNOR).
module pair_serial_tx #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_x,
  output logic             ser_y,
  output logic             ser_first,
  output logic             ser_last,
  output logic             done,
  output logic             all_eq,
  output logic             any_eq
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_sx, r_sy, w_sx_nxt, w_sy_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_and, r_or, w_and_nxt, w_or_nxt;
  logic               r_in_ready, r_ser_valid, r_first, r_last;
  logic               r_done, r_all_eq, r_any_eq;
  logic               w_in_ready_nxt, w_ser_valid_nxt, w_first_nxt, w_last_nxt;
  logic               w_done_nxt, w_all_eq_nxt, w_any_eq_nxt;
  logic               w_head_x, w_head_y, w_match, w_accept, w_xfer;
  logic [WIDTH-1:0]   w_sx_shift, w_sy_shift;

  // Head bit is the one currently on the wire; shifting moves the next bit into it.
  assign w_head_x   = MSB_FIRST ? r_sx[WIDTH-1] : r_sx[0];
  assign w_head_y   = MSB_FIRST ? r_sy[WIDTH-1] : r_sy[0];
  assign w_sx_shift = MSB_FIRST ? {r_sx[WIDTH-2:0], 1'b0} : {1'b0, r_sx[WIDTH-1:1]};
  assign w_sy_shift = MSB_FIRST ? {r_sy[WIDTH-2:0], 1'b0} : {1'b0, r_sy[WIDTH-1:1]};
  assign w_match    = ~(w_head_x ^ w_head_y);
  assign w_accept   = r_in_ready & in_valid;
  assign w_xfer     = r_ser_valid & ser_ready;

  always_comb begin
    w_state_nxt  = r_state;
    w_sx_nxt     = r_sx;
    w_sy_nxt     = r_sy;
    w_cnt_nxt    = r_cnt;
    w_and_nxt    = r_and;
    w_or_nxt     = r_or;
    w_done_nxt   = 1'b0;
    w_all_eq_nxt = r_all_eq;
    w_any_eq_nxt = r_any_eq;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_sx_nxt    = x_in;
          w_sy_nxt    = y_in;
          w_cnt_nxt   = '0;
          w_and_nxt   = 1'b1;
          w_or_nxt    = 1'b0;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (w_xfer) begin
          w_and_nxt = r_and & w_match;
          w_or_nxt  = r_or | w_match;
          if (r_cnt == LAST_CNT) begin
            // Final results include this last beat's contribution.
            w_state_nxt  = IDLE;
            w_done_nxt   = 1'b1;
            w_all_eq_nxt = r_and & w_match;
            w_any_eq_nxt = r_or | w_match;
          end else begin
            w_sx_nxt  = w_sx_shift;
            w_sy_nxt  = w_sy_shift;
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    w_in_ready_nxt  = (w_state_nxt == IDLE);
    w_ser_valid_nxt = (w_state_nxt == SHIFT);
    w_first_nxt     = (w_state_nxt == SHIFT) && (w_cnt_nxt == '0);
    w_last_nxt      = (w_state_nxt == SHIFT) && (w_cnt_nxt == LAST_CNT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_sx        <= '0;
      r_sy        <= '0;
      r_cnt       <= '0;
      r_and       <= 1'b0;
      r_or        <= 1'b0;
      r_in_ready  <= 1'b1;
      r_ser_valid <= 1'b0;
      r_first     <= 1'b0;
      r_last      <= 1'b0;
      r_done      <= 1'b0;
      r_all_eq    <= 1'b0;
      r_any_eq    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sx        <= w_sx_nxt;
      r_sy        <= w_sy_nxt;
      r_cnt       <= w_cnt_nxt;
      r_and       <= w_and_nxt;
      r_or        <= w_or_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_ser_valid <= w_ser_valid_nxt;
      r_first     <= w_first_nxt;
      r_last      <= w_last_nxt;
      r_done      <= w_done_nxt;
      r_all_eq    <= w_all_eq_nxt;
      r_any_eq    <= w_any_eq_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign ser_valid = r_ser_valid;
  assign ser_x     = w_head_x;
  assign ser_y     = w_head_y;
  assign ser_first = r_first;
  assign ser_last  = r_last;
  assign done      = r_done;
  assign all_eq    = r_all_eq;
  assign any_eq    = r_any_eq;

endmodule

// File: tb/tb_pair_serial_tx.sv
// Bench for pair_serial_tx: MSB-first and LSB-first instances share stimulus and
// are checked every cycle against a frame-level model, plus literal scenario checks.
module tb_pair_serial_tx;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic reset, in_valid, ser_ready;
  logic [W-1:0] x_in, y_in;

  logic m_in_ready, m_ser_valid, m_ser_x, m_ser_y, m_first, m_last, m_done, m_all, m_any;
  logic l_in_ready, l_ser_valid, l_ser_x, l_ser_y, l_first, l_last, l_done, l_all, l_any;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pair_serial_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(m_in_ready),
    .x_in(x_in), .y_in(y_in), .ser_valid(m_ser_valid), .ser_ready(ser_ready),
    .ser_x(m_ser_x), .ser_y(m_ser_y), .ser_first(m_first), .ser_last(m_last),
    .done(m_done), .all_eq(m_all), .any_eq(m_any));

  pair_serial_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(l_in_ready),
    .x_in(x_in), .y_in(y_in), .ser_valid(l_ser_valid), .ser_ready(ser_ready),
    .ser_x(l_ser_x), .ser_y(l_ser_y), .ser_first(l_first), .ser_last(l_last),
    .done(l_done), .all_eq(l_all), .any_eq(l_any));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level model: which pair is in flight and which beat index is on the wire.
  bit           md_en = 1'b0;
  bit           md_busy, md_done, md_all, md_any;
  int           md_k;
  logic [W-1:0] md_x, md_y;

  always @(posedge clk) begin
    if (reset) begin
      md_en = 1'b1; md_busy = 1'b0; md_k = 0;
      md_done = 1'b0; md_all = 1'b0; md_any = 1'b0;
    end else if (md_en) begin
      md_done = 1'b0;
      if (!md_busy) begin
        if (in_valid) begin
          md_busy = 1'b1; md_x = x_in; md_y = y_in; md_k = 0;
        end
      end else if (ser_ready) begin
        if (md_k == W - 1) begin
          md_busy = 1'b0;
          md_done = 1'b1;
          md_all  = (md_x == md_y);
          md_any  = ((~(md_x ^ md_y)) != '0);
        end else begin
          md_k++;
        end
      end
    end
  end

  task automatic cmp_inst(input string p, input bit msb, input logic ir, sv, sx, sy,
                          fi, la, dn, al, an);
    int idx;
    chk({p, " in_ready"},  ir, !md_busy);
    chk({p, " ser_valid"}, sv, md_busy);
    chk({p, " ser_first"}, fi, md_busy && md_k == 0);
    chk({p, " ser_last"},  la, md_busy && md_k == W - 1);
    chk({p, " done"},      dn, md_done);
    chk({p, " all_eq"},    al, md_all);
    chk({p, " any_eq"},    an, md_any);
    if (md_busy) begin
      idx = msb ? (W - 1 - md_k) : md_k;
      chk({p, " ser_x"}, sx, md_x[idx]);
      chk({p, " ser_y"}, sy, md_y[idx]);
    end
  endtask

  always @(negedge clk) begin
    if (md_en) begin
      cmp_inst("msb", 1'b1, m_in_ready, m_ser_valid, m_ser_x, m_ser_y, m_first, m_last,
               m_done, m_all, m_any);
      cmp_inst("lsb", 1'b0, l_in_ready, l_ser_valid, l_ser_x, l_ser_y, l_first, l_last,
               l_done, l_all, l_any);
    end
  end

  // Drives one pair (cycle 0 = accept cycle); stalls ser_ready over [st_lo, st_hi].
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input int st_lo,
                      input int st_hi, output int dc, output logic [W-1:0] bm,
                      output logic [W-1:0] bl, output logic fl);
    dc = -1; bm = '0; bl = '0; fl = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; x_in = x; y_in = y; ser_ready = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      in_valid  = 1'b0;
      x_in      = W'($urandom);
      y_in      = W'($urandom);
      ser_ready = !(c >= st_lo && c <= st_hi);
      if (m_ser_valid && ser_ready) bm = {bm[W-2:0], m_ser_x};
      if (l_ser_valid && ser_ready) bl = {l_ser_x, bl[W-1:1]};
      if (l_ser_valid && l_first && ser_ready) fl = l_ser_x;
      if (m_done) begin
        dc = c;
        break;
      end
    end
    ser_ready = 1'b1;
  endtask

  int           dc;
  logic [W-1:0] bm, bl;
  logic         fl;
  int           sel;

  initial begin
    reset = 1'b1; in_valid = 1'b0; x_in = '0; y_in = '0; ser_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst in_ready", m_in_ready, 1'b1);
    chk("rst ser_valid", m_ser_valid, 1'b0);
    chk("rst outs", {m_ser_x, m_ser_y, m_first, m_last, m_done, m_all, m_any}, 7'd0);
    reset = 1'b0;

    send(8'hA5, 8'hA5, 0, -1, dc, bm, bl, fl);
    chk("eq done cycle", 32'(dc), 32'd9);
    chk("eq msb bits", bm, 8'hA5);
    chk("eq lsb bits", bl, 8'hA5);
    chk("eq all/any/rdy", {m_all, m_any, m_in_ready}, 3'b111);

    send(8'h0F, 8'hF0, 0, -1, dc, bm, bl, fl);
    chk("cmpl done cycle", 32'(dc), 32'd9);
    chk("cmpl all/any", {m_all, m_any}, 2'b00);

    send(8'h80, 8'h7F, 0, -1, dc, bm, bl, fl);
    chk("80/7F all/any", {m_all, m_any}, 2'b00);

    send(8'h80, 8'h7E, 0, -1, dc, bm, bl, fl);
    chk("lastbeat all/any", {m_all, m_any}, 2'b01);
    chk("lastbeat lsb any", {l_all, l_any}, 2'b01);

    send(8'h3C, 8'h3C, 4, 6, dc, bm, bl, fl);
    chk("stall done cycle", 32'(dc), 32'd12);
    chk("stall bits", bm, 8'h3C);
    chk("stall all_eq", m_all, 1'b1);

    // Abort a frame with reset in cycle 5; the old all_eq=1 must be cleared.
    @(negedge clk);
    in_valid = 1'b1; x_in = 8'h55; y_in = 8'h55;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      reset = (c == 5);
    end
    chk("abort idle", {m_ser_valid, m_in_ready, m_done}, 3'b010);
    chk("abort results", {m_all, m_any, l_all, l_any}, 4'b0000);

    send(8'h01, 8'h01, 0, -1, dc, bm, bl, fl);
    chk("lsb first beat", fl, 1'b1);
    chk("lsb bits", bl, 8'h01);
    chk("lsb done cycle", 32'(dc), 32'd9);

    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      reset     = ($urandom_range(0, 249) == 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      ser_ready = ($urandom_range(0, 3) != 0);
      x_in      = W'($urandom);
      sel       = int'($urandom_range(0, 3));
      if (sel == 0) y_in = x_in;
      else if (sel == 1) y_in = ~x_in;
      else if (sel == 2) y_in = x_in ^ W'(1 << $urandom_range(0, W - 1));
      else y_in = W'($urandom);
    end
    reset = 1'b0; in_valid = 1'b0; ser_ready = 1'b1;
    repeat (20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
